tcdm_cache_bank_responder: RTL and testbench

Bank-side responder placed between one output port of the cache-bank crossbar and one cache bank data array. It accepts compacted-address TCDM requests under a credit limit and issues them to a fixed-latency bank array. It also rebuilds the full physical address for miss handling. Every request produces exactly one response, which is buffered and returned with its originating core_id under crossbar backpressure.

---
 rtl/tcdm_cache_pkg.sv | 18 +
 rtl/fifo_v3.sv | 43 ++++
 rtl/tcdm_cache_bank_responder.sv | 105 ++++++++++
 tb/tb_tcdm_cache_bank_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_cache_pkg.sv
// tcdm_cache_pkg: shared types and address reconstruction for the TCDM cache bank responder.
package tcdm_cache_pkg;
  localparam int unsigned DefCoreIdW = 2;
  localparam int unsigned DefDataW = 32;
  typedef logic [DefCoreIdW-1:0] core_id_t;
  typedef struct packed {
    logic [DefDataW-1:0] data;
    logic                write;
    core_id_t            core_id;
  } resp_t;
  // Re-inserts the bank select bits at bit position offset; callers truncate to their address width.
  function automatic logic [63:0] rebuild_addr(input logic [63:0] addr, input logic [5:0] offset,
                                               input logic [63:0] bank_id, input int unsigned sel_w);
    logic [63:0] low_mask;
    low_mask = (64'd1 << offset) - 64'd1;
    return (addr & low_mask) | (bank_id << offset) | ((addr & ~low_mask) << sel_w);
  endfunction
endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: Depth-entry FIFO with optional fall-through and asynchronous active-high reset.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned WIDTH        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_rd, r_wr;
  logic [CntW-1:0]  r_cnt;
  logic             w_empty, w_bypass, w_write, w_read;
  assign w_empty  = r_cnt == '0;
  assign w_bypass = FALL_THROUGH && w_empty && push_i;
  assign empty_o  = w_empty && !w_bypass;
  assign data_o   = w_bypass ? data_i : r_mem[r_rd];
  assign w_write  = push_i && !(w_bypass && pop_i);
  assign w_read   = pop_i && !w_empty;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_write) begin
        r_mem[r_wr] <= data_i;
        r_wr        <= (r_wr == LastPtr) ? '0 : r_wr + 1'b1;
      end
      if (w_read) r_rd <= (r_rd == LastPtr) ? '0 : r_rd + 1'b1;
      r_cnt <= r_cnt + CntW'(w_write) - CntW'(w_read);
    end
  end
endmodule

// File: rtl/tcdm_cache_bank_responder.sv
// tcdm_cache_bank_responder: credit-limited TCDM request issue to a fixed-latency bank with buffered responses.
// Optional TCDM_BANK_STATS_EN adds saturating accept/stall counters.
module tcdm_cache_bank_responder
  import tcdm_cache_pkg::*;
#(
  parameter int unsigned NumCore     = 4,
  parameter int unsigned NumCache    = 4,
  parameter int unsigned BankId      = 0,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned BankLatency = 1,
  parameter int unsigned Depth       = 4,
  localparam int unsigned CoreIdW    = (NumCore > 1) ? $clog2(NumCore) : 1,
  localparam int unsigned BeW        = DataWidth / 8,
  localparam int unsigned OffW       = $clog2(AddrWidth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [OffW-1:0]      dynamic_offset_i,
  input  logic                 q_valid_i,
  output logic                 q_ready_o,
  input  logic [AddrWidth-1:0] q_addr_i,
  input  logic                 q_write_i,
  input  logic [DataWidth-1:0] q_data_i,
  input  logic [BeW-1:0]       q_strb_i,
  input  logic [CoreIdW-1:0]   q_core_id_i,
  output logic                 bank_req_o,
  output logic                 bank_we_o,
  output logic [AddrWidth-1:0] bank_addr_o,
  output logic [AddrWidth-1:0] bank_full_addr_o,
  output logic [DataWidth-1:0] bank_wdata_o,
  output logic [BeW-1:0]       bank_be_o,
  input  logic [DataWidth-1:0] bank_rdata_i,
  output logic                 p_valid_o,
  input  logic                 p_ready_i,
  output logic [DataWidth-1:0] p_data_o,
  output logic                 p_write_o,
  output logic [CoreIdW-1:0]   p_core_id_o
`ifdef TCDM_BANK_STATS_EN
  ,
  output logic [31:0]          stat_req_o,
  output logic [31:0]          stat_stall_o
`endif
);
  localparam int unsigned SelW  = $clog2(NumCache);
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam int unsigned RespW = DataWidth + 1 + CoreIdW;
  localparam logic [CntW-1:0] Credits = CntW'(Depth);
  logic [CntW-1:0]    r_inflight;
  logic [CoreIdW+1:0] r_pipe [BankLatency];
  logic [CoreIdW+1:0] w_last;
  logic               w_accept, w_pop, w_empty;
  logic [RespW-1:0]   w_push_data, w_head;
  assign q_ready_o        = r_inflight < Credits;
  assign w_accept         = q_valid_i && q_ready_o;
  assign w_pop            = p_valid_o && p_ready_i;
  assign bank_req_o       = w_accept;
  assign bank_we_o        = q_write_i;
  assign bank_addr_o      = q_addr_i;
  assign bank_wdata_o     = q_data_i;
  assign bank_be_o        = q_strb_i;
  assign bank_full_addr_o = AddrWidth'(rebuild_addr(64'(q_addr_i), 6'(dynamic_offset_i), 64'(BankId), SelW));
  // Each stage holds {valid, write, core_id}; the last stage lines up with bank_rdata_i.
  assign w_last      = r_pipe[BankLatency-1];
  assign w_push_data = {w_last[CoreIdW] ? {DataWidth{1'b0}} : bank_rdata_i, w_last[CoreIdW], w_last[CoreIdW-1:0]};
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_inflight <= '0;
      for (int i = 0; i < BankLatency; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= {w_accept, q_write_i, q_core_id_i};
      for (int i = 1; i < BankLatency; i++) r_pipe[i] <= r_pipe[i-1];
      r_inflight <= r_inflight + CntW'(w_accept) - CntW'(w_pop);
    end
  end
  fifo_v3 #(
    .FALL_THROUGH(1'b0),
    .DEPTH       (Depth),
    .WIDTH       (RespW)
  ) u_resp_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (w_last[CoreIdW+1]),
    .data_i (w_push_data),
    .pop_i  (w_pop),
    .data_o (w_head),
    .empty_o(w_empty)
  );
  assign p_valid_o = !w_empty;
  assign {p_data_o, p_write_o, p_core_id_o} = w_head;
`ifdef TCDM_BANK_STATS_EN
  logic [31:0] r_stat_req, r_stat_stall;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stat_req   <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_accept && r_stat_req != '1) r_stat_req <= r_stat_req + 32'd1;
      if (q_valid_i && !q_ready_o && r_stat_stall != '1) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end
  assign stat_req_o   = r_stat_req;
  assign stat_stall_o = r_stat_stall;
`endif
endmodule

// File: tb/tb_tcdm_cache_bank_responder.sv
// tb_tcdm_cache_bank_responder: directed and random checks of two responder instances (BankLatency 1 and 2)
// against a queue-based reference model; stats are checked when TCDM_BANK_STATS_EN is defined.
module tb_tcdm_cache_bank_responder;
  localparam int DEPTH = 4;
  typedef struct {
    logic [31:0] data;
    logic        w;
    logic [1:0]  core;
    int          cyc;
  } ent_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  off = 5'd6;
  logic [1:0]  qv = '0;
  logic [31:0] qaddr = '0, qdata = '0;
  logic        qw = 1'b0, prdy = 1'b1;
  logic [3:0]  qstrb = '0;
  logic [1:0]  qcore = '0;
  logic [1:0]  qr, breq, bwe, pv, pw;
  logic [31:0] baddr [2], bfa [2], bwd [2], brd [2], pd [2];
  logic [3:0]  bbe [2];
  logic [1:0]  pc [2];
`ifdef TCDM_BANK_STATS_EN
  logic [31:0] sreq [2], sstall [2];
`endif
  int n_cmp = 0, n_err = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Splice the bank number into the address as a base-NumCache digit at position o.
  function automatic logic [31:0] exp_full(input logic [31:0] a, input int o, input int bid);
    longint unsigned p, lo, hi;
    p  = 64'd1 << o;
    lo = 64'(a) % p;
    hi = 64'(a) / p;
    return 32'((hi * 4 + 64'(bid)) * p + lo);
  endfunction

  tcdm_cache_bank_responder #(.BankId(2), .BankLatency(1), .Depth(DEPTH)) u_dut (
    .clk_i(clk), .rst_i(rst), .dynamic_offset_i(off),
    .q_valid_i(qv[0]), .q_ready_o(qr[0]), .q_addr_i(qaddr), .q_write_i(qw), .q_data_i(qdata),
    .q_strb_i(qstrb), .q_core_id_i(qcore),
    .bank_req_o(breq[0]), .bank_we_o(bwe[0]), .bank_addr_o(baddr[0]), .bank_full_addr_o(bfa[0]),
    .bank_wdata_o(bwd[0]), .bank_be_o(bbe[0]), .bank_rdata_i(brd[0]),
    .p_valid_o(pv[0]), .p_ready_i(prdy), .p_data_o(pd[0]), .p_write_o(pw[0]), .p_core_id_o(pc[0])
`ifdef TCDM_BANK_STATS_EN
    , .stat_req_o(sreq[0]), .stat_stall_o(sstall[0])
`endif
  );

  tcdm_cache_bank_responder #(.BankId(1), .BankLatency(2), .Depth(DEPTH)) u_dut_stream (
    .clk_i(clk), .rst_i(rst), .dynamic_offset_i(off),
    .q_valid_i(qv[1]), .q_ready_o(qr[1]), .q_addr_i(qaddr), .q_write_i(qw), .q_data_i(qdata),
    .q_strb_i(qstrb), .q_core_id_i(qcore),
    .bank_req_o(breq[1]), .bank_we_o(bwe[1]), .bank_addr_o(baddr[1]), .bank_full_addr_o(bfa[1]),
    .bank_wdata_o(bwd[1]), .bank_be_o(bbe[1]), .bank_rdata_i(brd[1]),
    .p_valid_o(pv[1]), .p_ready_i(prdy), .p_data_o(pd[1]), .p_write_o(pw[1]), .p_core_id_o(pc[1])
`ifdef TCDM_BANK_STATS_EN
    , .stat_req_o(sreq[1]), .stat_stall_o(sstall[1])
`endif
  );

  for (genvar g = 0; g < 2; g++) begin : m
    localparam int LAT = (g == 0) ? 1 : 2;
    localparam int BID = (g == 0) ? 2 : 1;
    ent_t sb[$];
    int mreq = 0, mstall = 0;
    logic rdy, epv;
    logic [31:0] s1, s2;
    // Bank array model: read data is a hash of the address, noise on idle cycles and writes.
    always @(posedge clk) begin
      s1 <= (breq[g] && !bwe[g]) ? hash(baddr[g]) : $urandom;
      s2 <= s1;
    end
    assign brd[g] = (LAT == 1) ? s1 : s2;
    always @(negedge clk) begin
      if (rst) begin
        sb.delete();
        mreq = 0;
        mstall = 0;
      end else begin
        rdy = sb.size() < DEPTH;
        epv = sb.size() > 0 && sb[0].cyc + LAT + 1 <= cyc;
        chk($sformatf("q_ready%0d", g), qr[g], rdy);
        chk($sformatf("bank_req%0d", g), breq[g], qv[g] && rdy);
        chk($sformatf("full_addr%0d", g), bfa[g], exp_full(qaddr, int'(off), BID));
        chk($sformatf("p_valid%0d", g), pv[g], epv);
        if (qv[g]) begin
          chk($sformatf("bank_addr%0d", g), baddr[g], qaddr);
          chk($sformatf("bank_sig%0d", g), {bwe[g], bbe[g], bwd[g]}, {qw, qstrb, qdata});
        end
        if (epv) begin
          chk($sformatf("p_data%0d", g), pd[g], sb[0].data);
          chk($sformatf("p_write%0d", g), pw[g], sb[0].w);
          chk($sformatf("p_core%0d", g), pc[g], sb[0].core);
          if (prdy) void'(sb.pop_front());
        end
        if (qv[g] && rdy) begin
          sb.push_back('{qw ? 32'd0 : hash(qaddr), qw, qcore, cyc});
          mreq++;
        end
        if (qv[g] && !rdy) mstall++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req();
    qaddr = $urandom;
    qdata = $urandom;
    qstrb = 4'($urandom);
    qcore = 2'($urandom);
  endtask

  task automatic idle(input int n);
    qv = '0;
    prdy = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_p_valid", pv[d], 1'b0);
      chk("rst_q_ready", qr[d], 1'b1);
      chk("rst_bank_req", breq[d], 1'b0);
      chk("rst_payload", {pd[d], pw[d], pc[d]}, 35'd0);
`ifdef TCDM_BANK_STATS_EN
      chk("rst_stats", {sreq[d], sstall[d]}, 64'd0);
`endif
    end
    step();
    step();
    rst = 1'b0;
    // single read
    step();
    qv[0] = 1'b1; qw = 1'b0; qaddr = 32'h0000_1234; qcore = 2'd3; qstrb = 4'hF;
    #1;
    chk("read_bank_req", breq[0], 1'b1);
    chk("read_full_addr", bfa[0], 32'h0000_48B4);
    step();
    qv[0] = 1'b0;
    #1 chk("read_not_yet", pv[0], 1'b0);
    step();
    #1;
    chk("read_valid", pv[0], 1'b1);
    chk("read_data", pd[0], hash(32'h0000_1234));
    chk("read_core", pc[0], 2'd3);
    // write ack
    step();
    qv[0] = 1'b1; qw = 1'b1; qcore = 2'd1; qdata = 32'hCAFE_F00D; qaddr = 32'h40;
    step();
    qv[0] = 1'b0; qw = 1'b0;
    step();
    #1;
    chk("wack_valid", pv[0], 1'b1);
    chk("wack_write", pw[0], 1'b1);
    chk("wack_data", pd[0], 32'd0);
    chk("wack_core", pc[0], 2'd1);
    // backpressure: 4 accepts then 10 stalled cycles
    step();
    prdy = 1'b0;
    for (int i = 0; i < 14; i++) begin
      qv[0] = 1'b1;
      rand_req();
      step();
    end
    qv[0] = 1'b0;
    prdy = 1'b1;
    #1;
    chk("bp_full_ready", qr[0], 1'b0);
    chk("bp_head_valid", pv[0], 1'b1);
`ifdef TCDM_BANK_STATS_EN
    chk("bp_stat_req", sreq[0], 32'(m[0].mreq));
    chk("bp_stat_stall", sstall[0], 32'(m[0].mstall));
`endif
    step();
    #1 chk("bp_ready_back", qr[0], 1'b1);
    idle(6);
    // streaming on the BankLatency=2 instance
    for (int i = 0; i < 16; i++) begin
      qv[1] = 1'b1; qw = 1'b0;
      rand_req();
      #1 chk("stream_ready", qr[1], 1'b1);
      step();
    end
    idle(8);
    // random traffic at the offset boundaries and a mid value
    for (int k = 0; k < 3; k++) begin
      off = (k == 0) ? 5'd0 : (k == 1) ? 5'd31 : 5'($urandom_range(1, 30));
      for (int i = 0; i < 150; i++) begin
        qv = 2'($urandom);
        qw = 1'($urandom);
        prdy = $urandom_range(0, 3) != 0;
        rand_req();
        step();
      end
      idle(12);
    end
    off = 5'd6;
    // reset with three responses pending
    prdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      qv[0] = 1'b1; qw = 1'b0;
      rand_req();
      step();
    end
    qv[0] = 1'b0;
    step();
    #1;
    chk("pre_rst_valid", pv[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", pv[0], 1'b0);
    chk("mid_rst_ready", qr[0], 1'b1);
    step();
    rst = 1'b0;
    idle(8);
    step();
    qv[0] = 1'b1; qw = 1'b0;
    rand_req();
    step();
    idle(6);
`ifdef TCDM_BANK_STATS_EN
    for (int d = 0; d < 2; d++) begin
      chk("end_stat_req", sreq[d], 32'(d == 0 ? m[0].mreq : m[1].mreq));
      chk("end_stat_stall", sstall[d], 32'(d == 0 ? m[0].mstall : m[1].mstall));
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
